// File: rtl/pong_timing_pkg.sv
// Default horizontal/vertical timing constants for the Pong TTL video chain.
// The vertical constants are only used when PONG_HSYNC_VCOUNT_EN is defined.
package pong_timing_pkg;

  localparam int CNT_W = 9;
  typedef logic [CNT_W-1:0] count_t;

  localparam int DEF_H_TOTAL     = 455;
  localparam int DEF_HBLANK_END  = 80;
  localparam int DEF_HSYNC_START = 32;
  localparam int DEF_HSYNC_END   = 64;

  localparam int DEF_V_TOTAL     = 262;
  localparam int DEF_VBLANK_END  = 16;
  localparam int DEF_VSYNC_START = 4;
  localparam int DEF_VSYNC_END   = 8;

endpackage

// File: rtl/sync_window_latch.sv
// Registered window decode: active is high while next_count lies in
// [WIN_START, WIN_END), so the output stays aligned with the counter it tracks.
module sync_window_latch
  import pong_timing_pkg::*;
#(
  parameter int WIN_START = 0,
  parameter int WIN_END   = 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   ce,
  input  count_t next_count,
  output logic   active,
  output logic   active_n
);

  localparam count_t START_C = count_t'(WIN_START);
  localparam count_t END_C   = count_t'(WIN_END);
  // Value the window takes at count 0, which is where reset parks the counter.
  localparam logic RESET_ACTIVE = (WIN_START == 0) && (WIN_END > 0);

  logic after_start;
  logic in_window;

  // A zero start is always satisfied; skipping the compare keeps it from being a constant test.
  if (WIN_START == 0) begin : g_start_zero
    assign after_start = 1'b1;
  end else begin : g_start_cmp
    assign after_start = (next_count >= START_C);
  end

  assign in_window = after_start && (next_count < END_C);

  // NOTE: non-blocking assignments so both outputs update on the same edge as the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= RESET_ACTIVE;
      active_n <= ~RESET_ACTIVE;
    end else if (ce) begin
      active   <= in_window;
      active_n <= ~in_window;
    end
  end

endmodule

// File: rtl/pong_hsync_gen.sv
// Horizontal timing stage: modulo-H_TOTAL counter with HBLANK/HSYNC window latches.
// Defining PONG_HSYNC_VCOUNT_EN adds the vertical counter and VBLANK/VSYNC latches.
module pong_hsync_gen
  import pong_timing_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int HBLANK_END  = DEF_HBLANK_END,
  parameter int HSYNC_START = DEF_HSYNC_START,
  parameter int HSYNC_END   = DEF_HSYNC_END
`ifdef PONG_HSYNC_VCOUNT_EN
  ,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int VBLANK_END  = DEF_VBLANK_END,
  parameter int VSYNC_START = DEF_VSYNC_START,
  parameter int VSYNC_END   = DEF_VSYNC_END
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  output logic [8:0]   h,
  output logic         hreset,
  output logic         hblank,
  output logic         hblank_n,
  output logic         hsync,
  output logic         hsync_n
`ifdef PONG_HSYNC_VCOUNT_EN
  ,
  output logic [8:0]   v,
  output logic         vreset,
  output logic         vblank,
  output logic         vblank_n,
  output logic         vsync,
  output logic         vsync_n
`endif
);

  if (!(HSYNC_START < HSYNC_END && HSYNC_END <= HBLANK_END &&
        HBLANK_END < H_TOTAL && H_TOTAL <= 512)) begin : g_bad_h_params
    $fatal(1, "pong_hsync_gen: illegal horizontal timing parameters");
  end

  localparam count_t H_LAST = count_t'(H_TOTAL - 1);

  count_t h_next;

  assign hreset = (h == H_LAST);

  always_comb begin
    h_next = hreset ? '0 : h + count_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)   h <= '0;
    else if (ce) h <= h_next;
  end

  sync_window_latch #(.WIN_START(0), .WIN_END(HBLANK_END)) u_hblank (
    .clk(clk), .reset(reset), .ce(ce), .next_count(h_next),
    .active(hblank), .active_n(hblank_n)
  );

  sync_window_latch #(.WIN_START(HSYNC_START), .WIN_END(HSYNC_END)) u_hsync (
    .clk(clk), .reset(reset), .ce(ce), .next_count(h_next),
    .active(hsync), .active_n(hsync_n)
  );

`ifdef PONG_HSYNC_VCOUNT_EN
  if (!(VSYNC_START < VSYNC_END && VSYNC_END <= VBLANK_END &&
        VBLANK_END < V_TOTAL && V_TOTAL <= 512)) begin : g_bad_v_params
    $fatal(1, "pong_hsync_gen: illegal vertical timing parameters");
  end

  localparam count_t V_LAST = count_t'(V_TOTAL - 1);

  count_t v_next;

  assign vreset = hreset && (v == V_LAST);

  // v only moves on the last pixel of a line; otherwise v_next is simply v.
  always_comb begin
    v_next = v;
    if (hreset) v_next = (v == V_LAST) ? '0 : v + count_t'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)   v <= '0;
    else if (ce) v <= v_next;
  end

  sync_window_latch #(.WIN_START(0), .WIN_END(VBLANK_END)) u_vblank (
    .clk(clk), .reset(reset), .ce(ce), .next_count(v_next),
    .active(vblank), .active_n(vblank_n)
  );

  sync_window_latch #(.WIN_START(VSYNC_START), .WIN_END(VSYNC_END)) u_vsync (
    .clk(clk), .reset(reset), .ce(ce), .next_count(v_next),
    .active(vsync), .active_n(vsync_n)
  );
`endif

endmodule

// File: tb/tb_pong_hsync_gen.sv
// Directed bench for pong_hsync_gen: default timing plus a small overridden instance.
// Vertical checks run only when PONG_HSYNC_VCOUNT_EN is defined.
module tb_pong_hsync_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b0;

  logic [8:0] h, h2;
  logic hreset, hblank, hblank_n, hsync, hsync_n;
  logic hreset2, hblank2, hblank2_n, hsync2, hsync2_n;
`ifdef PONG_HSYNC_VCOUNT_EN
  logic [8:0] v, v2;
  logic vreset, vblank, vblank_n, vsync, vsync_n;
  logic vreset2, vblank2, vblank2_n, vsync2, vsync2_n;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pong_hsync_gen dut (
    .clk(clk), .reset(reset), .ce(ce),
    .h(h), .hreset(hreset), .hblank(hblank), .hblank_n(hblank_n),
    .hsync(hsync), .hsync_n(hsync_n)
`ifdef PONG_HSYNC_VCOUNT_EN
    , .v(v), .vreset(vreset), .vblank(vblank), .vblank_n(vblank_n),
    .vsync(vsync), .vsync_n(vsync_n)
`endif
  );

  pong_hsync_gen #(.H_TOTAL(10), .HBLANK_END(4), .HSYNC_START(1), .HSYNC_END(3)) dut_small (
    .clk(clk), .reset(reset), .ce(ce),
    .h(h2), .hreset(hreset2), .hblank(hblank2), .hblank_n(hblank2_n),
    .hsync(hsync2), .hsync_n(hsync2_n)
`ifdef PONG_HSYNC_VCOUNT_EN
    , .v(v2), .vreset(vreset2), .vblank(vblank2), .vblank_n(vblank2_n),
    .vsync(vsync2), .vsync_n(vsync2_n)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample one time unit after the rising edge, well clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_h(input int cur, input int total);
    return (cur == total - 1) ? 0 : cur + 1;
  endfunction

  task automatic check_main(input int eh);
    logic eb, es;
    eb = (eh < 80);
    es = (eh >= 32) && (eh < 64);
    check("h", 32'(h), eh);
    check("hreset", 32'(hreset), 32'(eh == 454));
    check("hblank", 32'(hblank), 32'(eb));
    check("hblank_n", 32'(hblank_n), 32'(!eb));
    check("hsync", 32'(hsync), 32'(es));
    check("hsync_n", 32'(hsync_n), 32'(!es));
  endtask

  task automatic check_small(input int eh);
    logic eb, es;
    eb = (eh < 4);
    es = (eh >= 1) && (eh < 3);
    check("h_small", 32'(h2), eh);
    check("hreset_small", 32'(hreset2), 32'(eh == 9));
    check("hblank_small", 32'(hblank2), 32'(eb));
    check("hblank_n_small", 32'(hblank2_n), 32'(!eb));
    check("hsync_small", 32'(hsync2), 32'(es));
    check("hsync_n_small", 32'(hsync2_n), 32'(!es));
  endtask

  initial begin
    int eh, e2, wraps, hr_cnt, hb_cnt, hs_cnt;

    // Reset with ce low still clears everything.
    reset = 1'b1; ce = 1'b0;
    step();
    check_main(0);
    check_small(0);

    // Full line with ce tied high.
    reset = 1'b0; ce = 1'b1;
    eh = 0; wraps = 0; hr_cnt = 0; hb_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 455; i++) begin
      step();
      eh = next_h(eh, 455);
      if (eh == 0) wraps++;
      if (hreset) hr_cnt++;
      if (hblank) hb_cnt++;
      if (hsync) hs_cnt++;
      check_main(eh);
    end
    check("wraps_full", 32'(wraps), 1);
    check("hreset_count", 32'(hr_cnt), 1);
    check("hblank_count", 32'(hb_cnt), 80);
    check("hsync_count", 32'(hs_cnt), 32);

    // ce pulsed one cycle in four: same sequence, holding between pulses.
    wraps = 0;
    for (int i = 0; i < 1820; i++) begin
      ce = ((i % 4) == 0);
      step();
      if ((i % 4) == 0) begin
        eh = next_h(eh, 455);
        if (eh == 0) wraps++;
      end
      check_main(eh);
    end
    check("wraps_1in4", 32'(wraps), 1);

    // Reset mid-line at h=200 with ce high.
    ce = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      eh = next_h(eh, 455);
    end
    check_main(200);
    reset = 1'b1;
    step();
    eh = 0;
    check_main(0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      eh = next_h(eh, 455);
      check_main(i);
    end

    // Overridden small timing: period 10, hblank 0..3, hsync 1..2.
    reset = 1'b1;
    step();
    check_small(0);
    reset = 1'b0;
    e2 = 0; wraps = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      e2 = next_h(e2, 10);
      if (e2 == 0) wraps++;
      check_small(e2);
    end
    check("wraps_small", 32'(wraps), 2);

`ifdef PONG_HSYNC_VCOUNT_EN
    begin
      int ev, vwraps;
      logic eb, es;
      reset = 1'b1;
      step();
      check("v_reset", 32'(v2), 0);
      check("vblank_reset", 32'(vblank2), 1);
      check("vsync_reset", 32'(vsync2), 0);
      reset = 1'b0;
      e2 = 0; ev = 0; vwraps = 0;
      for (int i = 0; i < 262 * 10; i++) begin
        step();
        if (e2 == 9) begin
          ev = next_h(ev, 262);
          if (ev == 0) vwraps++;
        end
        e2 = next_h(e2, 10);
        eb = (ev < 16);
        es = (ev >= 4) && (ev < 8);
        check("v", 32'(v2), ev);
        check("vreset", 32'(vreset2), 32'((e2 == 9) && (ev == 261)));
        check("vblank", 32'(vblank2), 32'(eb));
        check("vblank_n", 32'(vblank2_n), 32'(!eb));
        check("vsync", 32'(vsync2), 32'(es));
        check("vsync_n", 32'(vsync2_n), 32'(!es));
      end
      check("v_wraps", 32'(vwraps), 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
